// File: rtl/mem_lsu_if.sv
// Data-bus interface between the load/store unit (master) and the memory system (slave).
// The request side holds steady from acceptance until the one-cycle ack.
interface mem_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: issues one outstanding data-bus request at a time,
// formats store lanes, extracts load data and writes the MEM/WB register.
module mem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    mem_lsu_if.master   dbus,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign
);

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    function automatic size_e size_of(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: size_of = SZ_B;
            3'b001, 3'b101: size_of = SZ_H;
            default:        size_of = SZ_W;
        endcase
    endfunction

    state_e state, state_nxt;

    // Request registers, held until ack.
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Fields needed at ack time to build the writeback.
    size_e       lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;
    logic        lat_reg_write;
    logic        lat_load;

    // Decode of the instruction currently in EX/MEM.
    size_e       cur_size;
    logic        is_mem_op;
    logic        is_load;
    logic        misaligned;
    logic        accept;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    // Load extraction from the returned word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign cur_size   = size_of(funct3);
    assign is_mem_op  = ex_valid & (mem_read | mem_write);
    assign is_load    = mem_read;
    assign misaligned = ((cur_size == SZ_H) & addr[0]) |
                        ((cur_size == SZ_W) & (addr[1:0] != 2'b00));
    assign accept     = is_mem_op & ~misaligned;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (cur_size)
            SZ_B: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            SZ_H: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte  = 8'(dbus.dbus_rdata >> {lat_off, 3'b000});
        ld_half  = lat_off[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
        ld_value = dbus.dbus_rdata;
        case (lat_size)
            SZ_B:    ld_value = lat_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_value = lat_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // stall is forced low in reset because ex_valid may be driven while held.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                stall = ~dbus.dbus_ack;
                if (dbus.dbus_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            lat_size      <= SZ_W;
            lat_unsigned  <= 1'b0;
            lat_off       <= '0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_load      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            misalign      <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ex_valid) begin
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end else if (!is_mem_op) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= addr;
                        wb_rd        <= rd;
                        wb_reg_write <= reg_write;
                    end else if (misaligned) begin
                        // Faulting access retires as a non-writing instruction.
                        wb_valid     <= 1'b1;
                        wb_data      <= addr;
                        wb_rd        <= rd;
                        wb_reg_write <= 1'b0;
                        misalign     <= 1'b1;
                    end else begin
                        wb_valid      <= 1'b0;
                        wb_reg_write  <= 1'b0;
                        req_q         <= 1'b1;
                        we_q          <= mem_write & ~is_load;
                        addr_q        <= {addr[31:2], 2'b00};
                        wdata_q       <= is_load ? 32'h0 : st_wdata;
                        wstrb_q       <= is_load ? 4'h0 : st_wstrb;
                        lat_size      <= cur_size;
                        lat_unsigned  <= funct3[2];
                        lat_off       <= addr[1:0];
                        lat_rd        <= rd;
                        lat_reg_write <= reg_write;
                        lat_load      <= is_load;
                    end
                end
                BUSY: begin
                    if (dbus.dbus_ack) begin
                        req_q        <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= lat_rd;
                        wb_data      <= ld_value;
                        wb_reg_write <= lat_load & lat_reg_write;
                    end else begin
                        wb_valid     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wdata = wdata_q;
    assign dbus.dbus_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu: pass-through, loads/stores of every
// size, misalignment, stray acks, back-to-back ops and reset during a transaction.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  rd;
    logic        stall, wb_valid, wb_reg_write, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    // Captured at the first request cycle of run_mem.
    logic        cap_req, cap_we, busy_wb, stable;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          sc;

    mem_lsu_if bus ();

    mem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .rd           (rd),
        .reg_write    (reg_write),
        .dbus         (bus.master),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] r, input logic rw);
        ex_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3;
        addr = a; store_data = sd; rd = r; reg_write = rw;
    endtask

    task automatic clr_ex();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; rd = '0; reg_write = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one memory op at posedge+1, acks n cycles after req rises,
    // perturbs EX inputs while busy, and returns at posedge+1 after the ack edge.
    task automatic run_mem(input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] r, input logic rw,
                           input int n, input logic [31:0] rdata);
        set_ex(mr, mw, f3, a, sd, r, rw);
        sc = 0; busy_wb = 1'b0; stable = 1'b1;
        #1 if (stall) sc++;
        next_cycle();
        cap_req = bus.dbus_req; cap_we = bus.dbus_we; cap_addr = bus.dbus_addr;
        cap_wdata = bus.dbus_wdata; cap_wstrb = bus.dbus_wstrb;
        for (int i = 0; i < n; i++) begin
            addr = ~a; funct3 = ~f3; store_data = ~sd;
            #1 if (stall) sc++;
            busy_wb |= wb_valid;
            next_cycle();
        end
        set_ex(mr, mw, f3, a, sd, r, rw);
        busy_wb |= wb_valid;
        bus.dbus_ack = 1'b1; bus.dbus_rdata = rdata;
        #1 if (stall) sc++;
        if (bus.dbus_req !== cap_req || bus.dbus_we !== cap_we || bus.dbus_addr !== cap_addr ||
            bus.dbus_wdata !== cap_wdata || bus.dbus_wstrb !== cap_wstrb) stable = 1'b0;
        next_cycle();
        bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h0;
        clr_ex();
    endtask

    initial begin
        bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h0;
        rst_n = 1'b0;
        set_ex(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd1, 1'b1);
        #12;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, bus.dbus_req}, 32'd0);
        check("rst_wstrb", {28'b0, bus.dbus_wstrb}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        clr_ex();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ALU pass-through.
        set_ex(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        #1 check("alu_stall", {31'b0, stall}, 32'd0);
        next_cycle();
        check("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("alu_wb_data", wb_data, 32'h0000_1234);
        check("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
        check("alu_wb_rw", {31'b0, wb_reg_write}, 32'd1);
        check("alu_req", {31'b0, bus.dbus_req}, 32'd0);
        clr_ex();
        next_cycle();
        check("bubble_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("bubble_wb_rw", {31'b0, wb_reg_write}, 32'd0);

        // LB sign-extension, ack two cycles after req.
        run_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 2, 32'h8012_3456);
        check("lb_req", {31'b0, cap_req}, 32'd1);
        check("lb_addr", cap_addr, 32'h100);
        check("lb_we", {31'b0, cap_we}, 32'd0);
        check("lb_stall_cycles", sc, 32'd3);
        check("lb_busy_wb", {31'b0, busy_wb}, 32'd0);
        check("lb_stable", {31'b0, stable}, 32'd1);
        check("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_rd", {27'b0, wb_rd}, 32'd7);
        check("lb_wb_rw", {31'b0, wb_reg_write}, 32'd1);
        check("lb_req_drop", {31'b0, bus.dbus_req}, 32'd0);

        // SH upper half, immediate ack.
        run_mem(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd9, 1'b1, 0, 32'h0);
        check("sh_wstrb", {28'b0, cap_wstrb}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        check("sh_we", {31'b0, cap_we}, 32'd1);
        check("sh_addr", cap_addr, 32'h200);
        check("sh_stall_cycles", sc, 32'd1);
        check("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("sh_wb_rw", {31'b0, wb_reg_write}, 32'd0);

        // LHU upper half.
        run_mem(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 5'd3, 1'b1, 1, 32'h8001_0000);
        check("lhu_wb_data", wb_data, 32'h0000_8001);
        check("lhu_stall_cycles", sc, 32'd2);

        // LH lower half, sign-extended.
        run_mem(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 5'd4, 1'b1, 0, 32'h1234_8765);
        check("lh_wb_data", wb_data, 32'hFFFF_8765);

        // LBU byte 1.
        run_mem(1'b1, 1'b0, 3'b100, 32'h701, 32'h0, 5'd6, 1'b1, 0, 32'h0000_F000);
        check("lbu_wb_data", wb_data, 32'h0000_00F0);

        // SB byte 1, with busy-time input perturbation.
        run_mem(1'b0, 1'b1, 3'b000, 32'h501, 32'h1234_565A, 5'd2, 1'b0, 2, 32'h0);
        check("sb_wstrb", {28'b0, cap_wstrb}, 32'h2);
        check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        check("sb_stable", {31'b0, stable}, 32'd1);

        // Both read and write with funct3=011: a word load.
        run_mem(1'b1, 1'b1, 3'b011, 32'h600, 32'h5555_5555, 5'd8, 1'b1, 0, 32'hDEAD_BEEF);
        check("rw_we", {31'b0, cap_we}, 32'd0);
        check("rw_wb_data", wb_data, 32'hDEAD_BEEF);
        check("rw_wb_rw", {31'b0, wb_reg_write}, 32'd1);

        // Misaligned LW.
        set_ex(1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 5'd4, 1'b1);
        #1 check("mis_lw_stall", {31'b0, stall}, 32'd0);
        next_cycle();
        check("mis_lw_req", {31'b0, bus.dbus_req}, 32'd0);
        check("mis_lw_flag", {31'b0, misalign}, 32'd1);
        check("mis_lw_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("mis_lw_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        clr_ex();
        next_cycle();
        check("mis_lw_pulse_end", {31'b0, misalign}, 32'd0);

        // Misaligned SH on an odd address.
        set_ex(1'b0, 1'b1, 3'b001, 32'h203, 32'h1, 5'd1, 1'b0);
        #1 check("mis_sh_stall", {31'b0, stall}, 32'd0);
        next_cycle();
        check("mis_sh_flag", {31'b0, misalign}, 32'd1);
        check("mis_sh_req", {31'b0, bus.dbus_req}, 32'd0);
        clr_ex();

        // Stray ack while idle.
        bus.dbus_ack = 1'b1;
        next_cycle();
        bus.dbus_ack = 1'b0;
        check("stray_req", {31'b0, bus.dbus_req}, 32'd0);
        check("stray_wb_valid", {31'b0, wb_valid}, 32'd0);

        // Store then load to the same word, back to back.
        run_mem(1'b0, 1'b1, 3'b010, 32'h800, 32'h1122_3344, 5'd0, 1'b0, 1, 32'h0);
        check("b2b_st_wstrb", {28'b0, cap_wstrb}, 32'hF);
        check("b2b_st_wdata", cap_wdata, 32'h1122_3344);
        check("b2b_gap_req", {31'b0, bus.dbus_req}, 32'd0);
        run_mem(1'b1, 1'b0, 3'b010, 32'h800, 32'h0, 5'd10, 1'b1, 0, 32'h1122_3344);
        check("b2b_ld_stall_cycles", sc, 32'd1);
        check("b2b_ld_addr", cap_addr, 32'h800);
        check("b2b_ld_wb_data", wb_data, 32'h1122_3344);
        check("b2b_ld_wb_rd", {27'b0, wb_rd}, 32'd10);

        // Reset in the middle of a transaction, then a stray ack.
        set_ex(1'b1, 1'b0, 3'b010, 32'h900, 32'h0, 5'd11, 1'b1);
        next_cycle();
        check("rb_req_before", {31'b0, bus.dbus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rb_req_async", {31'b0, bus.dbus_req}, 32'd0);
        check("rb_stall", {31'b0, stall}, 32'd0);
        clr_ex();
        next_cycle();
        rst_n = 1'b1;
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hFFFF_FFFF;
        next_cycle();
        bus.dbus_ack = 1'b0;
        check("rb_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rb_req_after", {31'b0, bus.dbus_req}, 32'd0);
        set_ex(1'b0, 1'b0, 3'b010, 32'h0000_CAFE, 32'h0, 5'd1, 1'b1);
        next_cycle();
        check("rb_idle_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("rb_idle_wb_data", wb_data, 32'h0000_CAFE);
        clr_ex();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
